reg30_io_bridge: RTL

Peripheral endpoint on the far side of the CPU's register-30 I/O port. It accepts CPU writes to r30 as commands, pushing data into a transmit FIFO drained by an external valid/ready sink. It buffers words from an external valid/ready source in a receive FIFO. It continuously presents a status-plus-data word back to the CPU on the r30 read value.

---
 rtl/reg30_io_pkg.sv | 38 +++
 rtl/reg30_io_bridge_if.sv | 22 ++
 rtl/reg30_io_bridge_fifo.sv | 51 +++++
 rtl/reg30_io_bridge.sv | 75 +++++++
 4 files changed

// File: rtl/reg30_io_pkg.sv
// Shared encodings for the r30 I/O bridge: command codes, status bit positions
// and the packer that builds the word the CPU reads back from r30.
package reg30_io_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_CLR  = 2'b11
  } cmd_e;

  localparam int STAT_RXNE  = 31;
  localparam int STAT_TXF   = 30;
  localparam int STAT_TXOVF = 29;
  localparam int STAT_RXUNF = 28;
  localparam int RXCNT_MSB  = 27;
  localparam int RXCNT_LSB  = 24;
  localparam int TXCNT_MSB  = 23;
  localparam int TXCNT_LSB  = 20;
  localparam int HEAD_MSB   = 15;

  function automatic logic [31:0] pack_status(input logic rxne, input logic txf,
                                              input logic ovf, input logic unf,
                                              input logic [3:0] rxc, input logic [3:0] txc,
                                              input logic [15:0] head);
    logic [31:0] s;
    s = '0;
    s[STAT_RXNE]              = rxne;
    s[STAT_TXF]               = txf;
    s[STAT_TXOVF]             = ovf;
    s[STAT_RXUNF]             = unf;
    s[RXCNT_MSB:RXCNT_LSB]    = rxc;
    s[TXCNT_MSB:TXCNT_LSB]    = txc;
    s[HEAD_MSB:0]             = head;
    return s;
  endfunction

endpackage

// File: rtl/reg30_io_bridge_if.sv
// CPU r30 port plus TX sink / RX source handshakes of the bridge.
interface reg30_io_bridge_if #(parameter int DATA_W = 16);
  logic              cpu_wr30;
  logic [31:0]       cpu_wdata;
  logic [31:0]       reg30_in;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;

  modport slave (
    input  cpu_wr30, cpu_wdata, tx_ready, rx_valid, rx_data,
    output reg30_in, tx_valid, tx_data, rx_ready
  );

  modport master (
    output cpu_wr30, cpu_wdata, tx_ready, rx_valid, rx_data,
    input  reg30_in, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/reg30_io_bridge_fifo.sv
// Small synchronous FIFO; callers never push while full or pop while empty.
module sync_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Power-of-two depth: pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/reg30_io_bridge.sv
// r30 I/O bridge: decodes CPU writes into TX push / RX pop / flag clear and
// presents status, counts and the RX head on the r30 read value.
module reg30_io_bridge
  import reg30_io_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  reg30_io_bridge_if.slave   bus
);

  cmd_e              cmd;
  logic              is_push, is_pop, is_clr;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]     tx_cnt, rx_cnt;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  assign cmd     = cmd_e'(bus.cpu_wdata[31:30]);
  assign is_push = bus.cpu_wr30 && (cmd == CMD_PUSH);
  assign is_pop  = bus.cpu_wr30 && (cmd == CMD_POP);
  assign is_clr  = bus.cpu_wr30 && (cmd == CMD_CLR);

  // A push into a full TX FIFO is dropped even if the sink frees a slot this edge.
  assign tx_push = is_push && !tx_full;
  assign tx_pop  = !tx_empty && bus.tx_ready;
  assign rx_push = bus.rx_valid && !rx_full;
  assign rx_pop  = is_pop && !rx_empty;

  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .wdata(bus.cpu_wdata[DATA_W-1:0]), .rdata(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .wdata(bus.rx_data), .rdata(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  // An overflow/underflow event outranks a clear on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (is_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (is_push && tx_full) ovf_d = 1'b1;
    if (is_pop && rx_empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.tx_valid = !rst && !tx_empty;
  assign bus.tx_data  = rst ? '0 : tx_head;
  assign bus.rx_ready = !rst && !rx_full;
  assign bus.reg30_in = rst ? '0 :
                        pack_status(!rx_empty, tx_full, ovf_q, unf_q,
                                    4'(rx_cnt), 4'(tx_cnt), 16'(rx_head));

endmodule
